layer_output_router: RTL

LAYER_OUTPUT_ROUTER -- requirements
Module: layer_output_router

---
 rtl/layer_output_router_pkg.sv | 26 ++
 rtl/layer_output_router_sync_fifo.sv | 57 +++++
 rtl/layer_output_router.sv | 125 ++++++++++++
 3 files changed

// File: rtl/layer_output_router_pkg.sv
// Shared types for the layer output router: layer modes, FSM states and
// width helpers used by the port declarations.
package layer_output_router_pkg;

    typedef enum logic [0:0] {
        FULLY_CONVOL = 1'b0,
        POOLING      = 1'b1
    } layer_mode_e;

    typedef enum logic [1:0] {
        ROUTE  = 2'd0,
        DRAIN  = 2'd1,
        SWITCH = 2'd2
    } router_state_e;

    // Width of a destination index; never zero so a single-destination build still elaborates.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Request width carries one extra code point so an out-of-range mode_sel is representable.
    function automatic int req_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/layer_output_router_sync_fifo.sv
// Single-clock FIFO holding the beats waiting to be routed.
// Pushes while full and pops while empty are ignored.
module sync_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  full,
    output logic                  empty
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [AW:0]           count_q, count_d;
    logic                  do_push, do_pop;

    always_comb begin
        full     = (count_q == (AW+1)'(FIFO_DEPTH));
        empty    = (count_q == '0);
        do_push  = push && !full;
        do_pop   = pop && !empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        if (do_push && !do_pop)      count_d = count_q + (AW+1)'(1);
        else if (!do_push && do_pop) count_d = count_q - (AW+1)'(1);
        rd_data = mem_q[rd_ptr_q];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset: the head is only observed while the FIFO is non-empty.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wr_data;
    end

endmodule

// File: rtl/layer_output_router.sv
// Routes buffered layer-output beats to the destination selected by the active
// layer mode; a mode change drains the buffer to the old destination first.
module layer_output_router
    import layer_output_router_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_DEST   = 2,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [req_width(NUM_DEST)-1:0]     mode_sel,
    input  logic                               mode_load,
    output logic [idx_width(NUM_DEST)-1:0]     mode_active,
    output logic                               mode_busy,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [DATA_WIDTH-1:0]              in_data,
    output logic [NUM_DEST-1:0]                out_valid,
    input  logic [NUM_DEST-1:0]                out_ready,
    output logic [NUM_DEST*DATA_WIDTH-1:0]     out_data,
    output logic [NUM_DEST*CNT_WIDTH-1:0]      beat_cnt,
    output logic                               mode_err
);

    localparam int IDX_W = idx_width(NUM_DEST);
    localparam int SEL_W = req_width(NUM_DEST);

    router_state_e                        state_q, state_d;
    logic [IDX_W-1:0]                     active_q, active_d;
    logic [IDX_W-1:0]                     pending_q, pending_d;
    logic                                 err_q, err_d;
    logic                                 run_q, run_d;
    logic [NUM_DEST-1:0][CNT_WIDTH-1:0]   cnt_q, cnt_d;

    logic                  push, pop, full, empty, sel_ok;
    logic [DATA_WIDTH-1:0] head;

    sync_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (push),
        .pop     (pop),
        .wr_data (in_data),
        .rd_data (head),
        .full    (full),
        .empty   (empty)
    );

    always_comb begin
        run_d     = 1'b1;
        state_d   = state_q;
        active_d  = active_q;
        pending_d = pending_q;
        err_d     = err_q;
        cnt_d     = cnt_q;
        out_valid = '0;
        out_data  = '0;

        // run_q holds in_ready low through reset and releases it one edge later.
        in_ready  = run_q && (state_q == ROUTE) && !full;
        push      = in_valid && in_ready;
        sel_ok    = (mode_sel < SEL_W'(NUM_DEST));

        for (int d = 0; d < NUM_DEST; d++) begin
            if (!empty && (active_q == IDX_W'(d))) begin
                out_valid[d]                         = 1'b1;
                out_data[d*DATA_WIDTH +: DATA_WIDTH] = head;
            end
            if (out_valid[d] && out_ready[d] && (cnt_q[d] != '1))
                cnt_d[d] = cnt_q[d] + CNT_WIDTH'(1);
        end
        pop = |(out_valid & out_ready);

        case (state_q)
            ROUTE: begin
                if (mode_load) begin
                    if (!sel_ok) begin
                        err_d = 1'b1;
                    end else begin
                        pending_d = IDX_W'(mode_sel);
                        state_d   = (empty && !push) ? SWITCH : DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (empty) state_d = SWITCH;
            end
            SWITCH: begin
                active_d = pending_q;
                cnt_d    = '0;
                state_d  = ROUTE;
            end
            default: state_d = ROUTE;
        endcase

        mode_busy   = (state_q != ROUTE);
        mode_active = active_q;
        mode_err    = err_q;
        beat_cnt    = cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ROUTE;
            active_q  <= '0;
            pending_q <= '0;
            err_q     <= 1'b0;
            run_q     <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            active_q  <= active_d;
            pending_q <= pending_d;
            err_q     <= err_d;
            run_q     <= run_d;
            cnt_q     <= cnt_d;
        end
    end

endmodule
